// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router input stage: route label
// encodings, flit field layout and the flit struct.
package noc_pkg;

    // Route labels presented to the switch allocator, one-hot {W,N,E,S}.
    localparam logic [3:0] LBL_W     = 4'b1000;
    localparam logic [3:0] LBL_N     = 4'b0100;
    localparam logic [3:0] LBL_E     = 4'b0010;
    localparam logic [3:0] LBL_S     = 4'b0001;
    localparam logic [3:0] LBL_LOCAL = 4'b0000;
    localparam logic [3:0] LBL_NONE  = 4'b1111;

    // Flit field boundaries (40-bit flit).
    localparam int SRC_MSB  = 39;
    localparam int DST_MSB  = 35;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 24;
    localparam int TYPE_MSB = 1;
    localparam int TYPE_LSB = 0;

    localparam int FLIT_W   = SRC_MSB + 1;

    // Flit layout: src | dst | timestamp | data | type.
    typedef struct packed {
        logic [SRC_MSB-DST_MSB-1:0]     src;
        logic [DST_MSB-TS_MSB-1:0]      dst;
        logic [TS_MSB-TS_LSB:0]         ts;
        logic [TS_LSB-TYPE_MSB-2:0]     data;
        logic [TYPE_MSB-TYPE_LSB:0]     ftype;
    } flit_t;

    // Hop-count timestamp increment that sticks at the maximum value.
    function automatic logic [7:0] ts_hop_inc(input logic [7:0] ts);
        return (ts == 8'hFF) ? 8'hFF : ts + 8'd1;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Occupancy is tracked in a registered counter; full/empty decode from it
// so neither flag has a combinational path from the push/pop inputs.
module noc_fifo #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [DATASIZE-1:0] i_wr_data,
    input  logic                i_pop,
    output logic [DATASIZE-1:0] o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [WIDTH:0]      o_count
);

    localparam logic [WIDTH:0] LP_DEPTH = (WIDTH+1)'(DEPTH);

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [WIDTH:0]      r_wr_ptr;
    logic [WIDTH:0]      r_rd_ptr;
    logic [WIDTH:0]      r_count;
    logic                w_push;
    logic                w_pop;

    // A push into a full FIFO and a pop from an empty one are both ignored.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap through the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full    = (r_count == LP_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr[WIDTH-1:0]];

endmodule

// File: rtl/noc_input_unit.sv
// Per-port ingress stage of the mesh router: buffers flits, computes the
// XY route label of the head flit and presents it to the switch allocator.
// Optional build macro NOC_HOP_COUNT_EN: when defined, the timestamp field
// of data_out is the stored timestamp plus one (saturating at 8'hFF).
//
// Handshakes: upstream presents data_valid_in with data_in and holds both
// stable while full=1; a flit is taken at a rising edge where
// data_valid_in=1 and full=0 (full sampled at the start of the cycle, a
// same-cycle pop does not make room). Downstream, label/data_out describe
// the head flit whenever label!=4'b1111; ready=1 at a rising edge pops it,
// and ready while empty is harmless.
module noc_input_unit
    import noc_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                data_valid_in,
    output logic                full,
    input  logic                ready,
    output logic [3:0]          label,
    output logic [DATASIZE-1:0] data_out,
    output logic [WIDTH:0]      count
);

    localparam logic [1:0] LP_CUR_X = 2'(CUR_X);
    localparam logic [1:0] LP_CUR_Y = 2'(CUR_Y);

    logic [DATASIZE-1:0] w_head_raw;
    logic                w_empty;
    flit_t               w_head_flit;
    flit_t               w_out_flit;
    logic [1:0]          w_dx;
    logic [1:0]          w_dy;
    logic [3:0]          w_route;

    noc_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .DATASIZE (DATASIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (data_valid_in),
        .i_wr_data (data_in),
        .i_pop     (ready),
        .o_rd_data (w_head_raw),
        .o_full    (full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    assign w_head_flit = flit_t'(w_head_raw);
    assign w_dx        = w_head_flit.dst[3:2];
    assign w_dy        = w_head_flit.dst[1:0];

    // Dimension-ordered routing: resolve X first, then Y, else eject.
    always_comb begin
        w_route = LBL_LOCAL;
        if (w_dx < LP_CUR_X) begin
            w_route = LBL_W;
        end else if (w_dx > LP_CUR_X) begin
            w_route = LBL_E;
        end else if (w_dy < LP_CUR_Y) begin
            w_route = LBL_N;
        end else if (w_dy > LP_CUR_Y) begin
            w_route = LBL_S;
        end
    end

    assign label = w_empty ? LBL_NONE : w_route;

    // Output flit: optional hop stamp on the timestamp, zero when empty.
    always_comb begin
        w_out_flit = w_head_flit;
`ifdef NOC_HOP_COUNT_EN
        w_out_flit.ts = ts_hop_inc(w_head_flit.ts);
`else
        w_out_flit.ts = w_head_flit.ts;
`endif
        data_out = w_empty ? '0 : DATASIZE'(w_out_flit);
    end

endmodule
